// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the dmem arbiter.
// DMEM_ARB_LOCK_EN adds the LOCKED state to the FSM encoding.
package dmem_arb_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int AW_DEF       = 6;
    localparam int DW_DEF       = 32;
    localparam int LOCK_MAX_DEF = 16;

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_e;
`endif

endpackage : dmem_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// winner and wraps, so every requester gets a turn within N picks.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;
    logic          found;

    // Walk the requesters in priority order and keep the first one asserted.
    // NOTE: every variable gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_i) + i) % N);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = cand;
            end
        end
        valid_o = found;
    end

endmodule : rr_pick

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters shared access to a
// single-port dmem with asynchronous read. One access per two cycles.
// Optional bus locking with timeout is built when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]    lock,
`endif
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
`ifdef DMEM_ARB_LOCK_EN
    output logic                  lock_err,
`endif
    output logic                  mem_we,
    output logic [AW-1:0]         mem_a,
    output logic [DW-1:0]         mem_d,
    input  logic [DW-1:0]         mem_q
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1) begin : g_param_check
        $error("dmem_arbiter: NUM_REQ must be 2..8 and LOCK_MAX at least 1");
    end

    // Per-requester views of the packed address and data buses.
    logic [AW-1:0] addr_a  [NUM_REQ];
    logic [DW-1:0] wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*AW +: AW];
        assign wdata_a[g] = wdata[g*DW +: DW];
    end

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      winner_q, winner_d;
    logic [NUM_REQ-1:0] winner_oh_q, winner_oh_d;
    logic [IW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [AW-1:0]      mem_a_q, mem_a_d;
    logic [DW-1:0]      mem_d_q, mem_d_d;
    logic               access_en;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_err_q, lock_err_d;
`endif

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State and datapath registers; reset also aborts an in-flight access.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            winner_q    <= '0;
            winner_oh_q <= '0;
            last_q      <= IW'(NUM_REQ - 1);
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_a_q     <= '0;
            mem_d_q     <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_cnt_q  <= '0;
            lock_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            winner_oh_q <= winner_oh_d;
            last_q      <= last_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_a_q     <= mem_a_d;
            mem_d_q     <= mem_d_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
            lock_err_q  <= lock_err_d;
`endif
        end
    end

    // Next-state logic and the memory/grant outputs of the ACCESS cycle.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        winner_oh_d = winner_oh_q;
        last_d      = last_q;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_a_d     = mem_a_q;
        mem_d_d     = mem_d_q;
        access_en   = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock_cnt_d  = lock_cnt_q;
        lock_err_d  = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_d    = pick_idx;
                    winner_oh_d = pick_oh;
                    state_d     = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // A withdrawn request or a reset in this cycle cancels the access.
                access_en = req[winner_q] && rst_n;
                state_d   = ST_IDLE;
                if (access_en) begin
                    last_d  = winner_q;
                    mem_a_d = addr_a[winner_q];
                    mem_d_d = wdata_a[winner_q];
                    if (!we[winner_q]) begin
                        rvalid_d = winner_oh_q;
                        rdata_d  = mem_q;
                    end
`ifdef DMEM_ARB_LOCK_EN
                    if (lock[winner_q]) begin
                        state_d = ST_LOCKED;
                    end
`endif
                end
            end

`ifdef DMEM_ARB_LOCK_EN
            ST_LOCKED: begin
                // The owner stays in winner_q; nobody else can be picked here.
                lock_cnt_d = lock_cnt_q + CW'(1);
                if (lock_cnt_q == CW'(LOCK_MAX - 1)) begin
                    state_d    = ST_IDLE;
                    lock_err_d = 1'b1;
                end else if (req[winner_q]) begin
                    state_d = ST_ACCESS;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef DMEM_ARB_LOCK_EN
        // The hold budget spans the whole lock, so it only clears on release.
        if (state_d == ST_IDLE) begin
            lock_cnt_d = '0;
        end
`endif

        gnt    = access_en ? winner_oh_q : '0;
        mem_we = access_en && we[winner_q];
        mem_a  = mem_a_d;
        mem_d  = mem_d_d;
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
`ifdef DMEM_ARB_LOCK_EN
    assign lock_err = lock_err_q;
`endif

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 6: word address width, matching the 64-word dmem.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter LOCK_MAX, default 16: maximum number of cycles a lock may be held (only with DMEM_ARB_LOCK_EN).
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock, all logic on its rising edge; rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have these requester-side ports:
- req  in  NUM_REQ  per-requester access request
- we  in  NUM_REQ  per-requester write enable
- addr  in  NUM_REQ*AW  packed word addresses
- wdata  in  NUM_REQ*DW  packed write data
- lock  in  NUM_REQ  per-requester lock request (only with DMEM_ARB_LOCK_EN)
- gnt  out  NUM_REQ  one-hot grant pulse
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse
- rdata  out  DW  read data shared by all requesters
- lock_err  out  1  lock timeout pulse (only with DMEM_ARB_LOCK_EN)
REQ-007 SHALL have these memory-side ports:
- mem_we  out  1  dmem write enable
- mem_a  out  AW  dmem address
- mem_d  out  DW  dmem write data
- mem_q  in  DW  dmem asynchronous read data

Function
REQ-008 FSM states SHALL be IDLE, ACCESS and LOCKED; LOCKED exists only with DMEM_ARB_LOCK_EN.
REQ-009 In IDLE with any req high, the winner SHALL be registered and the next state SHALL be ACCESS; with no req, the FSM SHALL stay in IDLE.
REQ-010 Winner selection SHALL be round-robin: the search starts at index last_winner+1 and wraps modulo NUM_REQ.
REQ-011 In ACCESS, gnt[winner] SHALL be high for exactly one cycle, and mem_a, mem_d and mem_we SHALL be driven from the winner's addr, wdata and we.
- Write: the memory commits on that clock edge.
- Read: mem_q SHALL be registered into rdata, and rvalid[winner] SHALL be high in the following cycle.
REQ-012 Outside ACCESS, mem_we SHALL be 0; mem_a and mem_d SHALL hold their last values.
REQ-013 After ACCESS the FSM SHALL return to IDLE, giving one access per 2 cycles at most.
REQ-014 Requester protocol: req, we, addr and wdata SHALL be held stable from req rise until the gnt cycle; req deasserted before grant means the request is withdrawn with no access.
REQ-015 A requester that keeps req high after gnt SHALL be treated as a new request and arbitrated in round-robin order.
REQ-016 rdata SHALL hold its value until the next read completes.
REQ-017 rvalid and gnt for different requesters MAY be high in the same cycle.
REQ-018 Simultaneous requests from all NUM_REQ requesters SHALL each be served exactly once within 2*NUM_REQ cycles.

Reset
REQ-019 While rst_n=0 at a clock edge, the block SHALL reset to:
- state=IDLE; gnt=0; rvalid=0; rdata=0
- mem_we=0; mem_a=0; mem_d=0
- last_winner=NUM_REQ-1, so requester 0 has first priority
- lock counter=0; lock_err=0
REQ-020 Reset asserted during ACCESS SHALL abort it: the write is suppressed in that cycle and no rvalid is issued.

Configuration
REQ-021 Macro DMEM_ARB_LOCK_EN SHALL control lock support.
- Defined: if lock[winner] is high in ACCESS, the next state SHALL be LOCKED and only that owner may be granted; LOCKED returns to ACCESS on the owner's req.
- Defined: the lock is released when the owner is granted with lock low, after which the FSM goes to IDLE.
- Defined: a counter SHALL count cycles in LOCKED; on reaching LOCK_MAX the FSM SHALL force IDLE and pulse lock_err for 1 cycle.
- Undefined: the lock port, lock_err, the LOCKED state and the counter SHALL be absent.

Structure
REQ-022 Package dmem_arb_pkg SHALL hold the state enum type and the default constants for NUM_REQ, AW, DW and LOCK_MAX.
REQ-023 The round-robin search SHALL be the sub-module rr_pick (combinational: req vector and last winner in, one-hot winner and valid out).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset; req=0001, we0=1, addr0=5, wdata0=0xDEADBEEF -> gnt=0001 at cycle 2, mem_we=1, mem_a=5; then a read of addr 5 by requester 2 -> rvalid=0100, rdata=0xDEADBEEF.
- req=1111 held continuously after reset -> grants in order 0001, 0010, 0100, 1000, 0001, spaced 2 cycles apart.
- Read of an unwritten address -> rdata=0xFFFFFFFF.
- rst_n=0 during the ACCESS cycle of a write to addr 3 -> memory word 3 unchanged, gnt=0, rvalid=0 next cycle.
- With DMEM_ARB_LOCK_EN: requester 1 locks and req=0011 -> requester 0 gets no gnt until requester 1 accesses with lock=0; holding the lock 16 cycles -> lock_err pulses and requester 0 is granted.
- req=0100 withdrawn in the same cycle the FSM enters IDLE -> no gnt, mem_we stays 0.
